// File: rtl/register_writeback_unit_if.sv
// Request bus into the register writeback unit.
// The producer (execute/memory stage) uses the master modport, the
// writeback unit uses the slave modport.
//   ReqValid/ReqReady : handshake, transfer on a rising edge when both high
//   ReqAddr/ReqLink   : destination register, ReqLink forces the link register
//   ReqSource         : 00 ALU, 01 memory, 10 PC, 11 byte immediate
//   ReqMerge          : 00 full word, 01 upper byte, 10 lower byte, 11 full word
//   ALUIN/MemoryIn/PCIN/ImmIn : candidate source data, sampled at accept only
interface register_writeback_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic                  ReqLink;
  logic [1:0]            ReqSource;
  logic [1:0]            ReqMerge;
  logic [DATA_WIDTH-1:0] ALUIN;
  logic [DATA_WIDTH-1:0] MemoryIn;
  logic [DATA_WIDTH-1:0] PCIN;
  logic [7:0]            ImmIn;

  modport master (
    output ReqValid, ReqAddr, ReqLink, ReqSource, ReqMerge,
           ALUIN, MemoryIn, PCIN, ImmIn,
    input  ReqReady
  );

  modport slave (
    input  ReqValid, ReqAddr, ReqLink, ReqSource, ReqMerge,
           ALUIN, MemoryIn, PCIN, ImmIn,
    output ReqReady
  );
endinterface

// File: rtl/register_writeback_unit.sv
// Register writeback unit: buffers register-file write requests in a small
// in-order FIFO and drives the register file's single write port. Byte-merge
// requests are performed as read-modify-write through the read port.
// Ports:
//   Clock, Reset   : rising-edge clock, synchronous active-low reset
//   req            : request bus (slave side), see register_writeback_unit_if
//   RdAddr/RdData  : register-file read port used for byte merges
//   WrAddr/WrData/WrEnable : register-file write port (registered)
//   PendingMask    : bit r set while any buffered or in-flight write targets r
//   Busy           : FIFO non-empty or a write sequence in progress
module register_writeback_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int LINK_REG   = 15
) (
  input  logic                       Clock,
  input  logic                       Reset,
  register_writeback_unit_if.slave   req,
  output logic [ADDR_WIDTH-1:0]      RdAddr,
  input  logic [DATA_WIDTH-1:0]      RdData,
  output logic [ADDR_WIDTH-1:0]      WrAddr,
  output logic [DATA_WIDTH-1:0]      WrData,
  output logic                       WrEnable,
  output logic [(1<<ADDR_WIDTH)-1:0] PendingMask,
  output logic                       Busy
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = PTR_W + 1;
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LINK_ADDR = ADDR_WIDTH'(LINK_REG);

  typedef enum logic [1:0] {IDLE, WRITE, READ, MERGE} stateT;

  stateT state;

  // FIFO storage and pointers
  logic [ADDR_WIDTH-1:0] entryAddr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] entryData  [FIFO_DEPTH];
  logic [1:0]            entryMerge [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [PTR_W-1:0]      rdPtrNext;
  logic [CNT_W-1:0]      count;

  // Incoming request after source mux and link override
  logic [ADDR_WIDTH-1:0] inAddr;
  logic [DATA_WIDTH-1:0] inData;
  logic [1:0]            inMerge;

  logic push;
  logic pop;

  // Entry that becomes the head once this edge's pop/push is applied
  logic                  nextValid;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic [DATA_WIDTH-1:0] nextData;
  logic [1:0]            nextMerge;

  logic [7:0]            headByte;
  logic [DATA_WIDTH-1:0] mergedData;

  assign req.ReqReady = (count < CNT_W'(FIFO_DEPTH));
  assign push         = req.ReqValid && req.ReqReady;
  assign pop          = (state == WRITE) || (state == MERGE);
  assign rdPtrNext    = rdPtr + 1'b1;
  assign Busy         = (count != '0) || (state != IDLE);

  assign inAddr  = req.ReqLink ? LINK_ADDR : req.ReqAddr;
  // Reserved merge encoding is stored as a plain full-word write.
  assign inMerge = (req.ReqMerge == 2'b11) ? 2'b00 : req.ReqMerge;

  always_comb begin
    inData = '0;
    case (req.ReqSource)
      2'b00:   inData = req.ALUIN;
      2'b01:   inData = req.MemoryIn;
      2'b10:   inData = req.PCIN;
      default: inData = DATA_WIDTH'(req.ImmIn);
    endcase
  end

  // Look-ahead to the next head so that a write request arriving at an empty
  // unit is already on the write port in the cycle after it was accepted, and
  // a stream of full writes retires one per cycle.
  always_comb begin
    nextValid = 1'b0;
    nextAddr  = inAddr;
    nextData  = inData;
    nextMerge = inMerge;
    if (pop) begin
      if (count > CNT_W'(1)) begin
        nextValid = 1'b1;
        nextAddr  = entryAddr[rdPtrNext];
        nextData  = entryData[rdPtrNext];
        nextMerge = entryMerge[rdPtrNext];
      end else if (push) begin
        nextValid = 1'b1;
      end
    end else if (state == IDLE) begin
      if (count != '0) begin
        nextValid = 1'b1;
        nextAddr  = entryAddr[rdPtr];
        nextData  = entryData[rdPtr];
        nextMerge = entryMerge[rdPtr];
      end else if (push) begin
        nextValid = 1'b1;
      end
    end
  end

  // Merge result from the register-file read data seen during READ. The merge
  // byte is always the low byte of the captured data, whatever the source.
  assign headByte = entryData[rdPtr][7:0];
  always_comb begin
    if (entryMerge[rdPtr] == 2'b01)
      mergedData = {headByte, RdData[DATA_WIDTH-9:0]};
    else
      mergedData = {RdData[DATA_WIDTH-1:8], headByte};
  end

  // Pending mask: one-hot of every valid slot, head included. Register 0 is
  // a discard target and never reported.
  logic [NUM_REGS-1:0] slotMask [FIFO_DEPTH];
  logic [NUM_REGS-1:0] pendingAll;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gSlot
    logic [PTR_W-1:0] offset;
    assign offset = PTR_W'(gi) - rdPtr;
    assign slotMask[gi] = ({1'b0, offset} < count) ?
                          (NUM_REGS'(1) << entryAddr[gi]) : '0;
  end

  always_comb begin
    pendingAll = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      pendingAll = pendingAll | slotMask[i];
  end

  assign PendingMask = pendingAll & ~NUM_REGS'(1);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      WrEnable <= 1'b0;
      WrAddr   <= '0;
      WrData   <= '0;
      RdAddr   <= '0;
    end else begin
      if (push) begin
        entryAddr[wrPtr]  <= inAddr;
        entryData[wrPtr]  <= inData;
        entryMerge[wrPtr] <= inMerge;
        wrPtr             <= wrPtr + 1'b1;
      end
      if (pop)
        rdPtr <= rdPtrNext;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (state == READ) begin
        // The read data is folded straight into the write data register, so
        // the merged word is presented during MERGE.
        WrEnable <= 1'b1;
        WrAddr   <= entryAddr[rdPtr];
        WrData   <= mergedData;
        state    <= MERGE;
      end else if (nextValid) begin
        if (nextMerge == 2'b00 || nextAddr == '0) begin
          // Register-0 entries pass through WRITE with the strobe held low,
          // so they drain without touching the port.
          state    <= WRITE;
          WrEnable <= (nextAddr != '0);
          if (nextAddr != '0) begin
            WrAddr <= nextAddr;
            WrData <= nextData;
          end
        end else begin
          state    <= READ;
          WrEnable <= 1'b0;
          RdAddr   <= nextAddr;
        end
      end else begin
        state    <= IDLE;
        WrEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_writeback_unit.sv
module tb_register_writeback_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  RdAddr;
  logic [15:0] RdData;
  logic [3:0]  WrAddr;
  logic [15:0] WrData;
  logic        WrEnable;
  logic [15:0] PendingMask;
  logic        Busy;

  register_writeback_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) rIf ();

  register_writeback_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(2), .LINK_REG(15)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req        (rIf),
    .RdAddr     (RdAddr),
    .RdData     (RdData),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .WrEnable   (WrEnable),
    .PendingMask(PendingMask),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  // Register file model attached to the DUT ports
  logic [15:0] rf [16];
  logic        rfClear = 1'b1;
  always @(posedge Clock) begin
    if (rfClear) begin
      for (int r = 0; r < 16; r++) rf[r] <= 16'h0000;
    end else if (WrEnable) begin
      rf[WrAddr] <= WrData;
    end
  end
  assign RdData = rf[RdAddr];

  int          checks = 0;
  int          errors = 0;
  logic [19:0] expQ [$];
  logic [15:0] model [16];

  // One clock, then scoreboard any write strobe visible in the new cycle.
  task automatic tick();
    logic [19:0] e;
    @(posedge Clock);
    #1;
    if (Reset && WrEnable) begin
      checks++;
      $display("write r%0d <= %h", WrAddr, WrData);
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=%h, required no write", WrAddr, WrData);
      end else begin
        e = expQ.pop_front();
        if ({WrAddr, WrData} !== e) begin
          errors++;
          $display("FAIL write_value: got r%0d=%h, required r%0d=%h", WrAddr, WrData, e[19:16], e[15:0]);
        end
      end
    end
  endtask

  task automatic sendReq(input logic [3:0] addr, input bit link, input logic [1:0] src,
                         input logic [1:0] merge, input logic [15:0] val, input logic [7:0] imm,
                         input bit expectWr, output int stalls);
    logic [3:0]  dest;
    logic [15:0] d;
    logic [15:0] e;
    logic [1:0]  m;
    rIf.ReqValid  = 1'b1;
    rIf.ReqAddr   = addr;
    rIf.ReqLink   = link;
    rIf.ReqSource = src;
    rIf.ReqMerge  = merge;
    rIf.ALUIN     = 16'($urandom);
    rIf.MemoryIn  = 16'($urandom);
    rIf.PCIN      = 16'($urandom);
    rIf.ImmIn     = imm;
    case (src)
      2'd0: rIf.ALUIN    = val;
      2'd1: rIf.MemoryIn = val;
      2'd2: rIf.PCIN     = val;
      default: ;
    endcase
    stalls = 0;
    while (!rIf.ReqReady && stalls < 20) begin
      tick();
      stalls++;
    end
    if (stalls >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ReqReady=0 for 20 cycles, required 1");
      rIf.ReqValid = 1'b0;
      return;
    end
    dest = link ? 4'd15 : addr;
    d    = (src == 2'd3) ? {8'h00, imm} : val;
    m    = (merge == 2'b11) ? 2'b00 : merge;
    if (expectWr && dest != 4'd0) begin
      if (m == 2'b01)      e = {d[7:0], model[dest][7:0]};
      else if (m == 2'b10) e = {model[dest][15:8], d[7:0]};
      else                 e = d;
      model[dest] = e;
      expQ.push_back({dest, e});
    end
    $display("req r%0d link=%0d src=%0d merge=%0d val=%h imm=%h", dest, link, src, merge, val, imm);
    tick();
    rIf.ReqValid = 1'b0;
    rIf.ALUIN    = 16'($urandom);
    rIf.MemoryIn = 16'($urandom);
    rIf.PCIN     = 16'($urandom);
    rIf.ImmIn    = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((Busy || expQ.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL drain_timeout: got Busy=%b queued=%0d, required idle", Busy, expQ.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    rfClear = 1'b0;
    Reset = 1'b1;
    checks++; if (rIf.ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", rIf.ReqReady); end
    checks++; if (WrEnable !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b required 0", WrEnable); end
    checks++; if (PendingMask !== 16'h0000) begin errors++; $display("FAIL reset_pending: got %h required 0000", PendingMask); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", Busy); end
    checks++; if ({WrAddr, WrData, RdAddr} !== 24'h0) begin errors++; $display("FAIL reset_ports: got %h/%h/%h required 0", WrAddr, WrData, RdAddr); end
  endtask

  task automatic test_full_write();
    int s;
    sendReq(4'd2, 1'b0, 2'd0, 2'b00, 16'hA5A5, 8'h00, 1'b1, s);
    checks++; if ({WrEnable, WrAddr, WrData} !== {1'b1, 4'd2, 16'hA5A5}) begin errors++; $display("FAIL full_write: got en=%b r%0d=%h required en=1 r2=a5a5", WrEnable, WrAddr, WrData); end
    checks++; if (PendingMask !== 16'h0004) begin errors++; $display("FAIL full_pending: got %h required 0004", PendingMask); end
    tick();
    checks++; if ({WrEnable, PendingMask} !== 17'h0) begin errors++; $display("FAIL full_after: got en=%b mask=%h required 0/0000", WrEnable, PendingMask); end
    checks++; if (WrData !== 16'hA5A5) begin errors++; $display("FAIL full_hold: got %h required a5a5", WrData); end
    drain();
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2;
    sendReq(4'd2, 1'b0, 2'd1, 2'b00, 16'h1234, 8'h00, 1'b1, s0);
    checks++; if ({WrEnable, WrAddr, WrData} !== {1'b1, 4'd2, 16'h1234}) begin errors++; $display("FAIL b2b_first: got en=%b r%0d=%h required en=1 r2=1234", WrEnable, WrAddr, WrData); end
    sendReq(4'd4, 1'b0, 2'd1, 2'b00, 16'h5678, 8'h00, 1'b1, s1);
    checks++; if ({WrEnable, WrAddr, WrData} !== {1'b1, 4'd4, 16'h5678}) begin errors++; $display("FAIL b2b_second: got en=%b r%0d=%h required en=1 r4=5678", WrEnable, WrAddr, WrData); end
    sendReq(4'd6, 1'b0, 2'd0, 2'b11, 16'h0F0F, 8'h00, 1'b1, s2);
    checks++; if (s0 + s1 + s2 !== 0) begin errors++; $display("FAIL b2b_stall: got %0d stall cycles required 0", s0 + s1 + s2); end
    drain();
  endtask

  task automatic test_merge();
    int s;
    sendReq(4'd4, 1'b0, 2'd3, 2'b01, 16'h0000, 8'hAB, 1'b1, s);
    checks++; if ({WrEnable, RdAddr} !== {1'b0, 4'd4}) begin errors++; $display("FAIL merge_read: got en=%b rd=%0d required en=0 rd=4", WrEnable, RdAddr); end
    checks++; if (PendingMask !== 16'h0010) begin errors++; $display("FAIL merge_pending: got %h required 0010", PendingMask); end
    tick();
    checks++; if ({WrEnable, WrAddr, WrData} !== {1'b1, 4'd4, 16'hAB78}) begin errors++; $display("FAIL merge_upper: got en=%b r%0d=%h required en=1 r4=ab78", WrEnable, WrAddr, WrData); end
    drain();
    // Full write then dependent lower merge: the read must see the new value.
    sendReq(4'd4, 1'b0, 2'd1, 2'b00, 16'h5678, 8'h00, 1'b1, s);
    sendReq(4'd4, 1'b0, 2'd3, 2'b10, 16'h0000, 8'hCD, 1'b1, s);
    checks++; if (RdAddr !== 4'd4) begin errors++; $display("FAIL merge_raw_read: got rd=%0d required 4", RdAddr); end
    tick();
    checks++; if ({WrEnable, WrData} !== {1'b1, 16'h56CD}) begin errors++; $display("FAIL merge_lower: got en=%b data=%h required en=1 56cd", WrEnable, WrData); end
    drain();
  endtask

  task automatic test_fifo_full();
    int s0, s1, s2, s3;
    sendReq(4'd8,  1'b0, 2'd0, 2'b01, 16'h12EF, 8'h00, 1'b1, s0);
    sendReq(4'd9,  1'b0, 2'd1, 2'b10, 16'h3344, 8'h00, 1'b1, s1);
    checks++; if (PendingMask !== 16'h0300) begin errors++; $display("FAIL full_fifo_pending: got %h required 0300", PendingMask); end
    checks++; if (rIf.ReqReady !== 1'b0) begin errors++; $display("FAIL full_fifo_ready: got %b required 0", rIf.ReqReady); end
    sendReq(4'd10, 1'b0, 2'd2, 2'b11, 16'hBEEF, 8'h00, 1'b1, s2);
    sendReq(4'd10, 1'b0, 2'd3, 2'b01, 16'h0000, 8'h7A, 1'b1, s3);
    checks++; if (s0 + s1 + s2 + s3 == 0) begin errors++; $display("FAIL full_fifo_stall: got 0 stall cycles required >0"); end
    drain();
  endtask

  task automatic test_link_zero();
    int s;
    sendReq(4'd3, 1'b1, 2'd2, 2'b00, 16'h0102, 8'h00, 1'b1, s);
    checks++; if ({WrEnable, WrAddr, WrData} !== {1'b1, 4'd15, 16'h0102}) begin errors++; $display("FAIL link_write: got en=%b r%0d=%h required en=1 r15=0102", WrEnable, WrAddr, WrData); end
    checks++; if (PendingMask !== 16'h8000) begin errors++; $display("FAIL link_pending: got %h required 8000", PendingMask); end
    drain();
    sendReq(4'd0, 1'b0, 2'd0, 2'b00, 16'hFFFF, 8'h00, 1'b1, s);
    checks++; if ({WrEnable, PendingMask} !== 17'h0) begin errors++; $display("FAIL zero_write: got en=%b mask=%h required 0/0000", WrEnable, PendingMask); end
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL zero_drain: got Busy=%b required 0", Busy); end
    sendReq(4'd0, 1'b0, 2'd3, 2'b01, 16'h0000, 8'h99, 1'b1, s);
    tick();
    tick();
    checks++; if ({Busy, WrEnable} !== 2'b00) begin errors++; $display("FAIL zero_merge: got Busy=%b en=%b required 0/0", Busy, WrEnable); end
    drain();
  endtask

  task automatic test_reset_mid_merge();
    int s;
    sendReq(4'd5, 1'b0, 2'd0, 2'b00, 16'h5555, 8'h00, 1'b1, s);
    drain();
    sendReq(4'd5, 1'b0, 2'd3, 2'b01, 16'h0000, 8'h11, 1'b0, s);
    checks++; if (RdAddr !== 4'd5) begin errors++; $display("FAIL midreset_read: got rd=%0d required 5", RdAddr); end
    Reset = 1'b0;
    tick();
    checks++; if ({WrEnable, WrAddr, WrData, RdAddr} !== 25'h0) begin errors++; $display("FAIL midreset_ports: got en=%b %h/%h/%h required 0", WrEnable, WrAddr, WrData, RdAddr); end
    checks++; if ({PendingMask, Busy, rIf.ReqReady} !== 18'h1) begin errors++; $display("FAIL midreset_status: got mask=%h busy=%b ready=%b required 0000/0/1", PendingMask, Busy, rIf.ReqReady); end
    Reset = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (rf[5] !== model[5]) begin errors++; $display("FAIL midreset_reg: got r5=%h required %h", rf[5], model[5]); end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) model[r] = 16'h0000;
    rIf.ReqValid  = 1'b0;
    rIf.ReqAddr   = 4'd0;
    rIf.ReqLink   = 1'b0;
    rIf.ReqSource = 2'd0;
    rIf.ReqMerge  = 2'd0;
    rIf.ALUIN     = 16'h0;
    rIf.MemoryIn  = 16'h0;
    rIf.PCIN      = 16'h0;
    rIf.ImmIn     = 8'h0;

    test_reset();
    test_full_write();
    test_back_to_back();
    test_merge();
    test_fifo_full();
    test_link_zero();
    test_reset_mid_merge();

    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL leftover_writes: got %0d queued required 0", expQ.size()); end
    for (int r = 1; r < 16; r++) begin
      checks++;
      if (rf[r] !== model[r]) begin errors++; $display("FAIL final_reg: got r%0d=%h required %h", r, rf[r], model[r]); end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_writeback_unit.md
Name: register_writeback_unit

Overview:
- Write-side counterpart of the decode subsystem: accepts register-file write requests from the execute/memory stages and drives the register file's single write port.
- Buffers requests in a small in-order FIFO.
- Performs read-modify-write for byte-merge writes (load-upper/load-lower immediate).
- Publishes a per-register pending mask that decode uses for stalls.

Parameters:
- DATA_WIDTH, 16, register and data width
- ADDR_WIDTH, 4, register address width (16 registers)
- FIFO_DEPTH, 2, request buffer entries (power of two, ≥2)
- LINK_REG, 15, register address written when ReqLink=1

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept a request this cycle
- ReqAddr  in  ADDR_WIDTH  destination register (ignored when ReqLink=1)
- ReqLink  in  1  override destination with LINK_REG
- ReqSource  in  2  00 ALU, 01 memory, 10 PC, 11 immediate
- ReqMerge  in  2  00 full word, 01 upper byte, 10 lower byte, 11 reserved (treated as 00)
- ALUIN  in  DATA_WIDTH  ALU result
- MemoryIn  in  DATA_WIDTH  memory read data
- PCIN  in  DATA_WIDTH  return address
- ImmIn  in  8  byte immediate, zero-extended for full writes
- RdAddr  out  ADDR_WIDTH  register-file read address for merges
- RdData  in  DATA_WIDTH  register-file read data (combinational from RdAddr)
- WrAddr  out  ADDR_WIDTH  register-file write address
- WrData  out  DATA_WIDTH  register-file write data
- WrEnable  out  1  write strobe, sampled by register file on rising edge
- PendingMask  out  2^ADDR_WIDTH  bit r set while any buffered/in-flight write targets r
- Busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Accept:
  - Handshake completes on a rising edge with ReqValid & ReqReady.
  - ReqReady = (count < FIFO_DEPTH), a registered function of count only. When full, no push that cycle even if a pop occurs.
  - At accept, source data is muxed and captured; ALUIN/MemoryIn/PCIN/ImmIn need not hold afterwards.
  - Stored entry: {addr, data16, merge}.
  - For merge modes the stored byte is data[7:0] for every source.
- Zero register:
  - Entries with addr 0 are popped as normal but WrEnable stays 0 (no RMW read issued).
  - PendingMask bit 0 is never set.
- FSM states IDLE, WRITE, READ, MERGE:
  - IDLE: if FIFO non-empty, go WRITE (merge=00) or READ (merge≠00).
  - WRITE: WrEnable=1, WrAddr/WrData = head entry. Pop. Go to WRITE/READ for next head if one exists, else IDLE. This allows back-to-back full writes, one per cycle.
  - READ: RdAddr=head addr; RdData registered into hold. Go MERGE.
  - MERGE: WrEnable=1.
    - Upper: WrData = {byte, hold[7:0]}.
    - Lower: WrData = {hold[15:8], byte}.
    - Pop, then next as WRITE.
- Latency (FIFO empty, request accepted at edge N):
  - Full write: WrEnable high in cycle N..N+1, committed at edge N+1.
  - Merge: READ in cycle after N, write committed at edge N+2.
- Ordering:
  - Strictly in-order. A merge following a write to the same register reads the updated value, because the prior write is committed before READ.
- PendingMask:
  - Combinational OR of one-hot(addr) over all valid entries, including the head currently in WRITE/READ/MERGE.
  - Bit clears the cycle after the final write to that register commits.
- Outputs when not writing: WrEnable=0; WrAddr, WrData, RdAddr hold the last values.
- Reset (Reset=0 at any edge, including mid-merge):
  - count=0, FSM IDLE, WrEnable=0, WrAddr=0, WrData=0, RdAddr=0, hold=0.
  - PendingMask=0, Busy=0, ReqReady=1 after the edge.
  - A partially completed merge is discarded; no write occurs.

Test Plan:
- Reset low 2 cycles, release → ReqReady=1, WrEnable=0, PendingMask=0, Busy=0.
- Accept full write addr 2, ALU source, ALUIN=A5A5 → next cycle WrEnable=1, WrAddr=2, WrData=A5A5; PendingMask bit2 set until commit.
- Back-to-back full writes to regs 2, 4 (MemoryIn=1234, 5678) with ReqValid held → WrEnable high two consecutive cycles with those values. A third request stalls (ReqReady=0) only if the FIFO fills.
- Reg 4 holds 5678; accept upper merge, ImmIn=AB → READ with RdAddr=4, then WrData=AB78. Lower merge with ImmIn=CD → 56CD.
- ReqLink=1, PC source, PCIN=0102, ReqAddr=3 → WrAddr=15, WrData=0102. Write to addr 0 → no WrEnable pulse, FIFO drains.
- Accept an upper merge, assert Reset=0 during READ → no WrEnable pulse follows; all outputs return to reset values.
